// File: rtl/array_lane_serializer_pkg.sv
// array_lane_pkg: shared FSM state type and lowest-set-bit helper for the lane serializer.
package array_lane_pkg;
    typedef enum logic {IDLE, SEND} state_e;
    function automatic logic [4:0] lowest_set(input logic [31:0] m);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) lowest_set = m[i] ? 5'(i) : lowest_set;
    endfunction
endpackage

// File: rtl/array_lane_serializer_if.sv
// array_lane_serializer_if: parallel-frame input and serial-beat output bundle.
interface array_lane_serializer_if #(parameter int TEST = 6);
    localparam int DW = TEST + 2;
    localparam int IW = $clog2(TEST);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data [TEST];
    logic          in_mask [TEST];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_first;
    logic          out_last;
    logic [15:0]   frame_cnt;
    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_first, out_last, frame_cnt
    );
    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_first, out_last, frame_cnt
    );
endinterface

// File: rtl/array_lane_serializer_prio.sv
// lane_prio_enc: combinational priority search returning the lowest enabled lane.
module lane_prio_enc
    import array_lane_pkg::*;
#(
    parameter int N = 6
) (
    input  logic [N-1:0]         mask,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int IW = $clog2(N);
    always_comb begin
        idx   = IW'(lowest_set(32'(mask)));
        found = |mask;
    end
endmodule

// File: rtl/array_lane_serializer.sv
// array_lane_serializer: emits the enabled lanes of a parallel frame as serial beats,
// lowest lane first, with back-to-back frame acceptance on the last beat.
module array_lane_serializer
    import array_lane_pkg::*;
#(
    parameter int TEST = 6
) (
    input logic                    clk,
    input logic                    rst,
    array_lane_serializer_if.slave bus
);
    localparam int DW = TEST + 2;
    localparam int IW = $clog2(TEST);

    state_e        state_q, state_d;
    logic [DW-1:0] data_q [TEST];
    logic [DW-1:0] data_d [TEST];
    logic [TEST-1:0] mask_q, mask_d, rem, in_mask_v;
    logic          first_q, first_d;
    logic          rdy_q;
    logic [15:0]   cnt_q, cnt_d;
    logic [IW-1:0] idx;
    logic          found, send, fire, done, accept;

    lane_prio_enc #(.N(TEST)) u_enc (.mask(mask_q), .idx(idx), .found(found));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '{default: '0};
            mask_q  <= '0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

    // mask_q holds only the lanes still to be sent; the encoder picks the current beat
    always_comb begin
        for (int i = 0; i < TEST; i++) in_mask_v[i] = bus.in_mask[i];
        accept  = bus.in_valid && bus.in_ready;
        fire    = send && bus.out_ready;
        state_d = done ? IDLE : state_q;
        mask_d  = fire ? rem : mask_q;
        first_d = fire ? 1'b0 : first_q;
        cnt_d   = done ? cnt_q + 16'd1 : cnt_q;
        data_d  = data_q;
        if (accept && |in_mask_v) begin
            state_d = SEND;
            mask_d  = in_mask_v;
            first_d = 1'b1;
            data_d  = bus.in_data;
        end
    end

    always_comb begin
        rem           = mask_q & (mask_q - TEST'(1));
        send          = (state_q == SEND) && found;
        done          = send && bus.out_ready && (rem == '0);
        bus.out_valid = send;
        bus.out_data  = data_q[idx];
        bus.out_idx   = idx;
        bus.out_first = send && first_q;
        bus.out_last  = send && (rem == '0);
        bus.in_ready  = rdy_q && ((state_q == IDLE) || done);
        bus.frame_cnt = cnt_q;
    end
endmodule

// File: tb/tb_array_lane_serializer.sv
// tb_array_lane_serializer: directed and random frames checked against a beat-queue model.
module tb_array_lane_serializer;
    localparam int TEST = 8;
    localparam int DW   = TEST + 2;

    typedef struct {
        logic [2:0]    idx;
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    array_lane_serializer_if #(.TEST(TEST)) bus ();
    array_lane_serializer #(.TEST(TEST)) dut (.clk(clk), .rst(rst), .bus(bus));

    beat_t       exp_q[$];
    logic [15:0] exp_cnt = '0;
    bit          rdy_ok = 1'b0;
    bit          seq_data = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge: check visible outputs, drive one cycle of stimulus, update model at posedge
    task automatic step(input bit iv, input logic [7:0] m, input bit ordy);
        logic [DW-1:0] d [TEST];
        bit   exp_rdy, acc_out;
        beat_t b;
        int   lanes[$];
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_idx", 32'(bus.out_idx), 32'(exp_q[0].idx));
            chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
            chk("out_first", 32'(bus.out_first), 32'(exp_q[0].first));
            chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
        end
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        for (int i = 0; i < TEST; i++) begin
            d[i] = seq_data ? DW'(i + 1) : DW'($urandom);
            bus.in_data[i] = d[i];
            bus.in_mask[i] = m[i];
        end
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        exp_rdy = rdy_ok && (exp_q.size() == 0 || (exp_q[0].last && ordy));
        acc_out = exp_q.size() > 0 && ordy;
        #1 chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (acc_out) begin
            b = exp_q.pop_front();
            if (b.last) exp_cnt++;
        end
        if (iv && exp_rdy) begin
            for (int i = 0; i < TEST; i++) if (m[i]) lanes.push_back(i);
            for (int k = 0; k < lanes.size(); k++)
                exp_q.push_back('{idx: 3'(lanes[k]), data: d[lanes[k]],
                                  first: k == 0, last: k == lanes.size() - 1});
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        chk("rst_out_first", 32'(bus.out_first), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        exp_q.delete();
        exp_cnt = '0;
        rdy_ok  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready_low", 32'(bus.in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        rdy_ok = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < TEST; i++) begin
            bus.in_data[i] = '0;
            bus.in_mask[i] = 1'b0;
        end
        @(negedge clk);
        pulse_reset();
        // full frame with sequential payloads
        seq_data = 1'b1;
        step(1, 8'hFF, 1);
        repeat (9) step(0, 8'h00, 1);
        seq_data = 1'b0;
        // sparse mask
        step(1, 8'h24, 1);
        repeat (3) step(0, 8'h00, 1);
        // all-zero mask accepted twice
        step(1, 8'h00, 1);
        step(1, 8'h00, 1);
        repeat (2) step(0, 8'h00, 1);
        // stall on first beat
        step(1, 8'h81, 1);
        repeat (3) step(0, 8'h00, 0);
        repeat (3) step(0, 8'h00, 1);
        // back-to-back frames, second presented during the first's last beat
        step(1, 8'h06, 1);
        step(0, 8'h00, 1);
        step(1, 8'h30, 1);
        repeat (4) step(0, 8'h00, 1);
        // single-lane frame
        step(1, 8'h10, 1);
        repeat (2) step(0, 8'h00, 1);
        // reset during beat 3 of a full frame
        step(1, 8'hFF, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        pulse_reset();
        seq_data = 1'b1;
        step(1, 8'hFF, 1);
        repeat (9) step(0, 8'h00, 1);
        seq_data = 1'b0;
        // random traffic with backpressure and input churn
        repeat (400) step(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                          $urandom_range(0, 3) != 0);
        repeat (20) step(0, 8'h00, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
